// File: rtl/crc8_rx_check.sv
// Receive-side CRC-8 (poly 0x07) checker: strips the trailing CRC byte, moves LAST
// onto the final payload byte and pulses end-of-frame status (ok / runt / length).
module crc8_rx_check #(
  parameter logic [7:0]  INIT  = 8'h00,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             stat_valid,
  output logic             stat_ok,
  output logic             stat_runt,
  output logic [LEN_W-1:0] stat_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       crc_q, crc_d, crc_nx;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic             m_valid_d, m_last_d;
  logic [7:0]       m_data_d;
  logic             stat_valid_d, stat_ok_d, stat_runt_d;
  logic [LEN_W-1:0] stat_len_d;
  logic             in_fire, out_fire;

  // Byte-parallel CRC-8 update, x = crc ^ data
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    logic [7:0] r;
    x    = c ^ d;
    r[0] = x[0] ^ x[6] ^ x[7];
    r[1] = x[0] ^ x[1] ^ x[6];
    r[2] = x[0] ^ x[1] ^ x[2] ^ x[6];
    r[3] = x[1] ^ x[2] ^ x[3] ^ x[7];
    r[4] = x[2] ^ x[3] ^ x[4];
    r[5] = x[3] ^ x[4] ^ x[5];
    r[6] = x[4] ^ x[5] ^ x[6];
    r[7] = x[5] ^ x[6] ^ x[7];
    return r;
  endfunction

  // No skid buffer: accept only when the output register is free or draining
  assign s_ready  = !rst && (!m_valid || m_ready);
  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;
  assign crc_nx   = crc8_step(crc_q, s_data);
  assign len_inc  = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      hold_q     <= 8'h00;
      crc_q      <= INIT;
      len_q      <= '0;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      stat_valid <= 1'b0;
      stat_ok    <= 1'b0;
      stat_runt  <= 1'b0;
      stat_len   <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      m_valid    <= m_valid_d;
      m_data     <= m_data_d;
      m_last     <= m_last_d;
      stat_valid <= stat_valid_d;
      stat_ok    <= stat_ok_d;
      stat_runt  <= stat_runt_d;
      stat_len   <= stat_len_d;
    end
  end

  // Hold-back: each payload byte is released only once the next byte shows it is not the CRC
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    crc_d        = crc_q;
    len_d        = len_q;
    m_valid_d    = m_valid && !out_fire;
    m_data_d     = m_data;
    m_last_d     = m_last;
    stat_valid_d = 1'b0;
    stat_ok_d    = 1'b0;
    stat_runt_d  = 1'b0;
    stat_len_d   = '0;
    if (in_fire) begin
      crc_d = s_last ? INIT : crc_nx;
      case (state_q)
        EMPTY: begin
          if (s_last) begin
            stat_valid_d = 1'b1;
            stat_runt_d  = 1'b1;
          end else begin
            hold_d  = s_data;
            state_d = HOLD;
          end
        end
        HOLD: begin
          m_valid_d = 1'b1;
          m_data_d  = hold_q;
          m_last_d  = s_last;
          if (s_last) begin
            stat_valid_d = 1'b1;
            stat_ok_d    = (crc_nx == 8'h00);
            stat_len_d   = len_inc;
            len_d        = '0;
            state_d      = EMPTY;
          end else begin
            hold_d = s_data;
            len_d  = len_inc;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_rx_check.sv
// Directed bench for crc8_rx_check: frame-level scoreboard plus literal checks.
module tb_crc8_rx_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b1;

  logic        s_ready, m_valid, m_last, stat_valid, stat_ok, stat_runt;
  logic [7:0]  m_data;
  logic [15:0] stat_len;
  logic        s_ready2, m_valid2, m_last2, stat_valid2, stat_ok2, stat_runt2;
  logic [7:0]  m_data2;
  logic [2:0]  stat_len2;

  int vectors = 0;
  int miscompares = 0;
  bit rand_ready = 1'b0;

  crc8_rx_check dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .stat_valid(stat_valid), .stat_ok(stat_ok),
    .stat_runt(stat_runt), .stat_len(stat_len)
  );

  // Narrow length counter so saturation is reachable with a short frame
  crc8_rx_check #(.LEN_W(3)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
    .m_last(m_last2), .stat_valid(stat_valid2), .stat_ok(stat_ok2),
    .stat_runt(stat_runt2), .stat_len(stat_len2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC over a whole byte sequence
  function automatic logic [7:0] crc_of(input logic [7:0] b[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (b[i]) begin
      c = c ^ b[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Frame-level model state
  logic [7:0] cur[$];
  logic [8:0] exp_out[$];
  logic       exp_sv, exp_ok, exp_runt;
  int         exp_len;
  int         stat_cnt = 0, out_cnt = 0;
  logic       last_ok, last_runt;
  int         last_len;
  logic [7:0] tail_data;

  always @(posedge clk) begin
    exp_sv = 1'b0;
    if (rst) begin
      cur.delete();
      exp_out.delete();
    end else begin
      chk("s_ready", 32'(s_ready), 32'(!m_valid || m_ready));
      chk("s_ready2", 32'(s_ready2), 32'(!m_valid2 || m_ready));
      if (m_valid && m_ready) begin
        if (exp_out.size() == 0) chk("unexpected_out", 32'(m_data), 32'hFFFF_FFFF);
        else begin
          chk("m_data", 32'(m_data), 32'(exp_out[0][7:0]));
          chk("m_last", 32'(m_last), 32'(exp_out[0][8]));
          if (m_valid2) begin
            chk("m_data2", 32'(m_data2), 32'(exp_out[0][7:0]));
            chk("m_last2", 32'(m_last2), 32'(exp_out[0][8]));
          end
          if (m_last) tail_data = m_data;
          void'(exp_out.pop_front());
          out_cnt++;
        end
      end
      if (s_valid && s_ready) begin
        if (cur.size() > 0) exp_out.push_back({s_last, cur[$]});
        cur.push_back(s_data);
        if (s_last) begin
          exp_sv   = 1'b1;
          exp_runt = (cur.size() == 1);
          exp_ok   = (crc_of(cur) == 8'h00) && !exp_runt;
          exp_len  = cur.size() - 1;
          cur.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_last", 32'(m_last), 0);
      chk("rst_stat", 32'({stat_valid, stat_ok, stat_runt}), 0);
      chk("rst_stat_len", 32'(stat_len), 0);
      chk("rst_s_ready", 32'(s_ready), 0);
    end else begin
      chk("stat_valid", 32'(stat_valid), 32'(exp_sv));
      chk("stat_valid2", 32'(stat_valid2), 32'(exp_sv));
      if (exp_sv) begin
        chk("stat_ok", 32'(stat_ok), 32'(exp_ok));
        chk("stat_runt", 32'(stat_runt), 32'(exp_runt));
        chk("stat_len", 32'(stat_len), 32'(exp_len));
        chk("stat_ok2", 32'(stat_ok2), 32'(exp_ok));
        chk("stat_runt2", 32'(stat_runt2), 32'(exp_runt));
        chk("stat_len2_sat", 32'(stat_len2), 32'((exp_len > 7) ? 7 : exp_len));
      end
      if (stat_valid) begin
        stat_cnt++;
        last_ok   = stat_ok;
        last_runt = stat_runt;
        last_len  = int'(stat_len);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(posedge clk);
      acc = s_ready;
      n++;
      #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i], i == b.size() - 1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] chk_q[$];
    int base;

    chk_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", 32'(crc_of(chk_q)), 32'hF4);
    chk_q = '{8'h01};
    chk("model_crc_01", 32'(crc_of(chk_q)), 32'h07);
    chk_q = '{8'h80};
    chk("model_crc_80", 32'(crc_of(chk_q)), 32'h89);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    send_frame(q);
    idle(3);
    chk("f1_ok", 32'(last_ok), 1);
    chk("f1_runt", 32'(last_runt), 0);
    chk("f1_len", 32'(last_len), 9);
    chk("f1_tail", 32'(tail_data), 32'h39);
    chk("f1_out_cnt", 32'(out_cnt), 9);

    q = '{8'h01, 8'h07};
    send_frame(q);
    idle(3);
    chk("f2_ok", 32'(last_ok), 1);
    chk("f2_len", 32'(last_len), 1);
    chk("f2_tail", 32'(tail_data), 32'h01);
    q = '{8'h01, 8'h08};
    send_frame(q);
    idle(3);
    chk("f3_bad_ok", 32'(last_ok), 0);
    chk("f3_len", 32'(last_len), 1);

    base = out_cnt;
    q = '{8'h00};
    send_frame(q);
    idle(3);
    chk("runt_ok", 32'(last_ok), 0);
    chk("runt_flag", 32'(last_runt), 1);
    chk("runt_len", 32'(last_len), 0);
    chk("runt_no_out", 32'(out_cnt - base), 0);

    rand_ready = 1'b1;
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    send_frame(q);
    rand_ready = 1'b0;
    idle(4);
    chk("bp_ok", 32'(last_ok), 1);
    chk("bp_len", 32'(last_len), 9);

    base = stat_cnt;
    q = '{8'h01, 8'h07, 8'h01, 8'h08};
    send_byte(q[0], 1'b0);
    send_byte(q[1], 1'b1);
    send_byte(q[2], 1'b0);
    send_byte(q[3], 1'b1);
    idle(3);
    chk("b2b_pulses", 32'(stat_cnt - base), 2);
    chk("b2b_second_ok", 32'(last_ok), 0);

    base = stat_cnt;
    q = '{8'h31, 8'h32, 8'h33, 8'h34};
    foreach (q[i]) send_byte(q[i], 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    q = '{8'h01, 8'h07};
    send_frame(q);
    idle(3);
    chk("abort_pulses", 32'(stat_cnt - base), 1);
    chk("abort_ok", 32'(last_ok), 1);
    chk("abort_len", 32'(last_len), 1);

    idle(5);
    chk("drain_exp_out", 32'(exp_out.size()), 0);
    chk("total_pulses", 32'(stat_cnt), 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
